// File: rtl/mem_access_unit.sv
// Load/store unit: captures one pipeline op, runs it as a single bus transaction and returns write-back data.
// Optional misaligned-access exceptions are enabled by defining MEM_ALIGN_CHECK_EN.

module mem_access_unit #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_ready,
  input  logic                  pipe_flush,
  output logic                  pipe_valid,
  input  logic                  in_read,
  input  logic                  in_write,
  input  logic [1:0]            in_size,
  input  logic                  in_unsigned,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic                  in_rd_we,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  exc_misalign,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [LANE_W-1:0] align_mask(input logic [1:0] size);
    return LANE_W'((4'd1 << size) - 4'd1);
  endfunction

  function automatic logic [NB-1:0] byte_strobe(input logic [LANE_W-1:0] lane, input logic [1:0] size);
    int unsigned nbytes;
    logic [NB-1:0] m;
    nbytes = 32'd1 << size;
    if (nbytes > NB) begin
      nbytes = NB;
    end else begin
      nbytes = nbytes;
    end
    m = {NB{1'b1}} >> (NB - nbytes);
    return m << lane;
  endfunction

  // The field's top bit is the lone mask bit not covered by the mask shifted right by one.
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] data,
                                                     input logic [LANE_W-1:0] lane,
                                                     input logic [1:0] size,
                                                     input logic uns);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] mask;
    int unsigned nbits;
    logic sgn;
    sh    = data >> {lane, 3'b000};
    nbits = 32'd8 << size;
    if (nbits > DATA_W) begin
      nbits = DATA_W;
    end else begin
      nbits = nbits;
    end
    mask = {DATA_W{1'b1}} >> (DATA_W - nbits);
    sgn  = |(sh & mask & ~(mask >> 1));
    return (!uns && sgn) ? (sh | ~mask) : (sh & mask);
  endfunction

  state_t                  r_state, w_next_state;
  logic                    r_read, r_write, r_unsigned, r_rd_we;
  logic [1:0]              r_size;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_wdata;
  logic [REG_ADDR_W-1:0]   r_rd;
  logic                    r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [DATA_W-1:0]       r_rbuf;
  logic                    r_rbuf_valid;

  logic                    w_in_mis, w_exc, w_in_go, w_go_store, w_go_load;
  logic                    w_is_load, w_read_hs, w_resp_hs;
  logic [LANE_W-1:0]       w_lane;
  logic [ADDR_W-1:0]       w_bus_addr;
  logic [DATA_W-1:0]       w_addr_data;
  logic [DATA_W-1:0]       w_load_src;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_in_mis = |(in_addr[LANE_W-1:0] & align_mask(in_size));
  assign w_exc    = (r_read | r_write) & (|(r_addr[LANE_W-1:0] & align_mask(r_size)));
`else
  assign w_in_mis = 1'b0;
  assign w_exc    = 1'b0;
`endif

  assign w_in_go    = pipe_ready & ~pipe_flush & (in_read | in_write) & ~w_in_mis;
  assign w_go_store = w_in_go & in_write;
  assign w_go_load  = w_in_go & ~in_write;

  assign w_is_load  = r_read & ~r_write;
  assign w_read_hs  = (r_state == ST_ACTIVE) & w_is_load & m_rvalid & r_rready;
  assign w_resp_hs  = w_read_hs | ((r_state == ST_ACTIVE) & r_write & m_bvalid & r_bready);

  // Without the alignment check, sub-size address bits are dropped.
  assign w_lane     = r_addr[LANE_W-1:0] & ~align_mask(r_size);
  assign w_bus_addr = {r_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};

  generate
    if (ADDR_W >= DATA_W) begin : g_addr_trunc
      assign w_addr_data = r_addr[DATA_W-1:0];
    end else begin : g_addr_ext
      assign w_addr_data = {{(DATA_W - ADDR_W){1'b0}}, r_addr};
    end
  endgenerate

  // Captures the stage inputs; a flush turns the op into a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_rd_we    <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= 2'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
    end else if (pipe_ready) begin
      r_read     <= in_read & ~pipe_flush;
      r_write    <= in_write & ~pipe_flush;
      r_rd_we    <= in_rd_we & ~pipe_flush;
      r_unsigned <= in_unsigned;
      r_size     <= in_size;
      r_addr     <= in_addr;
      r_wdata    <= in_wdata;
      r_rd       <= in_rd;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    if (pipe_ready) begin
      if (w_in_go) begin
        w_next_state = ST_ACTIVE;
      end else begin
        w_next_state = ST_IDLE;
      end
    end else begin
      case (r_state)
        ST_IDLE:   w_next_state = ST_IDLE;
        ST_ACTIVE: w_next_state = w_resp_hs ? ST_DONE : ST_ACTIVE;
        ST_DONE:   w_next_state = ST_DONE;
        default:   w_next_state = ST_IDLE;
      endcase
    end
  end

  // Bus handshake flags: all raised on entry to ACTIVE, each cleared by its own handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else if (pipe_ready) begin
      r_awvalid <= w_go_store;
      r_wvalid  <= w_go_store;
      r_bready  <= w_go_store;
      r_arvalid <= w_go_load;
      r_rready  <= w_go_load;
    end else begin
      if (r_awvalid && m_awready) r_awvalid <= 1'b0;
      if (r_wvalid && m_wready)   r_wvalid  <= 1'b0;
      if (r_bready && m_bvalid)   r_bready  <= 1'b0;
      if (r_arvalid && m_arready) r_arvalid <= 1'b0;
      if (r_rready && m_rvalid)   r_rready  <= 1'b0;
    end
  end

  // Holds read data after the handshake so DONE can keep presenting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rbuf       <= '0;
      r_rbuf_valid <= 1'b0;
    end else if (pipe_ready) begin
      r_rbuf_valid <= 1'b0;
    end else if (w_read_hs) begin
      r_rbuf       <= m_rdata;
      r_rbuf_valid <= 1'b1;
    end
  end

  assign w_load_src   = r_rbuf_valid ? r_rbuf : m_rdata;

  assign pipe_valid   = (r_state != ST_ACTIVE) | w_resp_hs | w_exc;
  assign wb_we        = r_rd_we & ~w_exc;
  assign wb_rd        = r_rd;
  assign wb_data      = w_is_load ? load_extract(w_load_src, w_lane, r_size, r_unsigned) : w_addr_data;
  assign exc_misalign = w_exc;

  assign m_awaddr  = w_bus_addr;
  assign m_araddr  = w_bus_addr;
  assign m_awvalid = r_awvalid;
  assign m_wvalid  = r_wvalid;
  assign m_bready  = r_bready;
  assign m_arvalid = r_arvalid;
  assign m_rready  = r_rready;
  assign m_wdata   = r_wdata << {w_lane, 3'b000};
  assign m_wstrb   = byte_strobe(w_lane, r_size);

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit (DATA_W=32) with a transaction-level reference model.

module tb_mem_access_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pipe_ready, pipe_flush, in_read, in_write, in_unsigned, in_rd_we;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        pipe_valid, wb_we, exc_misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .pipe_ready(pipe_ready), .pipe_flush(pipe_flush), .pipe_valid(pipe_valid),
    .in_read(in_read), .in_write(in_write), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd_we(in_rd_we), .in_rd(in_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .exc_misalign(exc_misalign),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic        chk_en = 1'b0;
  logic        e_pv, e_aw, e_w, e_b, e_ar, e_r, e_exc, e_we;
  logic [4:0]  e_rd;
  logic        e_wb_chk, e_st_chk, e_ld_chk;
  logic [31:0] e_wb, e_addr, e_wdata;
  logic [3:0]  e_strb;

  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference for a load: take the sized field at the lane, then sign- or zero-extend it.
  function automatic logic [31:0] model_load(input logic [31:0] d, input int lane, input int nb, input logic uns);
    longint unsigned f, lim;
    lim = 64'd1 << (8 * nb);
    f = (64'(d) >> (8 * lane)) % lim;
    if (!uns && f >= lim / 2) f = f - lim;
    return f[31:0];
  endfunction

  // Counts completed bus handshakes.
  always @(posedge clk) begin
    if (m_awvalid && m_awready) aw_cnt <= aw_cnt + 1;
    if (m_wvalid && m_wready)   w_cnt  <= w_cnt + 1;
    if (m_bvalid && m_bready)   b_cnt  <= b_cnt + 1;
    if (m_arvalid && m_arready) ar_cnt <= ar_cnt + 1;
    if (m_rvalid && m_rready)   r_cnt  <= r_cnt + 1;
  end

  // Compares DUT outputs against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pipe_valid", pipe_valid, e_pv);
      check("m_awvalid", m_awvalid, e_aw);
      check("m_wvalid", m_wvalid, e_w);
      check("m_bready", m_bready, e_b);
      check("m_arvalid", m_arvalid, e_ar);
      check("m_rready", m_rready, e_r);
      check("exc_misalign", exc_misalign, e_exc);
      check("wb_we", wb_we, e_we);
      check("wb_rd", wb_rd, e_rd);
      if (e_wb_chk) check("wb_data", wb_data, e_wb);
      if (e_st_chk) begin
        check("m_awaddr", m_awaddr, e_addr);
        check("m_wstrb", m_wstrb, e_strb);
        check("m_wdata", m_wdata, e_wdata);
      end
      if (e_ld_chk) check("m_araddr", m_araddr, e_addr);
    end
  end

  task automatic set_idle_exp();
    e_pv = 1'b1; e_aw = 1'b0; e_w = 1'b0; e_b = 1'b0; e_ar = 1'b0; e_r = 1'b0;
  endtask

  task automatic run_op(input logic rd_i, input logic wr_i, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic rwe,
                        input logic [4:0] rdi, input logic flush, input logic [31:0] rdata,
                        input int aw_d, input int w_d, input int ar_d, input int r_d, input int b_d,
                        output logic [31:0] o_wb, output logic [31:0] o_addr,
                        output logic [3:0] o_strb, output logic [31:0] o_wdata, output int o_hsk);
    bit acc, mis, st, ld, aw_p, w_p, b_p, ar_p, r_p, hs, done;
    int nb, lane, k, aw0, w0, b0, ar0, r0;
    logic [63:0] t;
    logic [31:0] exp_ld;
    o_wb = '0; o_addr = '0; o_strb = '0; o_wdata = '0; o_hsk = -1;
    @(posedge clk); #1;
    pipe_ready = 1'b1; pipe_flush = flush; in_read = rd_i; in_write = wr_i; in_size = sz;
    in_unsigned = uns; in_addr = addr; in_wdata = wd; in_rd_we = rwe; in_rd = rdi;
    @(posedge clk); #1;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
    pipe_ready = 1'b0; pipe_flush = 1'b0;
    in_read = 1'($urandom_range(0, 1)); in_write = 1'($urandom_range(0, 1)); in_addr = $urandom;
    in_wdata = $urandom; in_rd = 5'($urandom); in_size = 2'($urandom); in_rd_we = 1'($urandom_range(0, 1));
    acc  = (rd_i || wr_i) && !flush;
    nb   = 1 << sz;
    mis  = ALIGN_EN && acc && (addr % nb != 0);
    lane = ((addr % 4) / nb) * nb;
    st   = acc && wr_i && !mis;
    ld   = acc && !wr_i && !mis;
    t    = 64'(wd) << (8 * lane);
    exp_ld  = model_load(rdata, lane, nb, uns);
    e_exc   = mis;
    e_we    = rwe && !flush && !mis;
    e_rd    = rdi;
    e_addr  = addr & ~32'd3;
    e_strb  = 4'(((1 << nb) - 1) << lane);
    e_wdata = t[31:0];
    e_st_chk = st;
    e_ld_chk = ld;
    if (!st && !ld) begin
      set_idle_exp();
      e_wb_chk = !acc;
      e_wb     = addr;
      #2; o_wb = wb_data;
      @(negedge clk);
    end else begin
      aw_p = st; w_p = st; b_p = st; ar_p = ld; r_p = ld; done = 1'b0; k = 0;
      while (!done && k < 40) begin
        m_awready = aw_p && k >= aw_d;
        m_wready  = w_p && k >= w_d;
        m_arready = ar_p && k >= ar_d;
        m_bvalid  = st && !aw_p && !w_p && k >= b_d;
        m_rvalid  = ld && !ar_p && k >= r_d;
        m_rdata   = m_rvalid ? rdata : $urandom;
        hs = (m_bvalid && b_p) || (m_rvalid && r_p);
        e_aw = aw_p; e_w = w_p; e_b = b_p; e_ar = ar_p; e_r = r_p;
        e_pv = hs; e_wb_chk = hs && ld; e_wb = exp_ld;
        #2;
        if (k == 0) begin
          o_addr = st ? m_awaddr : m_araddr; o_strb = m_wstrb; o_wdata = m_wdata;
        end
        if (hs) begin
          o_wb = wb_data; o_hsk = k;
        end
        @(negedge clk);
        @(posedge clk);
        if (m_awready && aw_p) aw_p = 1'b0;
        if (m_wready && w_p)   w_p  = 1'b0;
        if (m_arready && ar_p) ar_p = 1'b0;
        if (hs) begin
          b_p = 1'b0; r_p = 1'b0; done = 1'b1;
        end
        #1; k++;
      end
      check("op_completes", done, 1'b1);
      m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b0;
      m_rdata = $urandom;
      set_idle_exp();
      e_wb_chk = ld; e_wb = exp_ld;
      @(negedge clk);
      check("aw_txns", aw_cnt - aw0, st ? 1 : 0);
      check("w_txns", w_cnt - w0, st ? 1 : 0);
      check("b_txns", b_cnt - b0, st ? 1 : 0);
      check("ar_txns", ar_cnt - ar0, ld ? 1 : 0);
      check("r_txns", r_cnt - r0, ld ? 1 : 0);
    end
  endtask

  logic [31:0] o_wb, o_addr, o_wdata;
  logic [3:0]  o_strb;
  int          o_hsk;

  initial begin
    rst = 1'b1; pipe_ready = 1'b0; pipe_flush = 1'b0; in_read = 1'b0; in_write = 1'b0;
    in_size = 2'd0; in_unsigned = 1'b0; in_addr = '0; in_wdata = '0; in_rd_we = 1'b0; in_rd = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    set_idle_exp();
    e_exc = 1'b0; e_we = 1'b0; e_rd = 5'd0; e_wb_chk = 1'b1; e_wb = 32'd0; e_st_chk = 1'b0; e_ld_chk = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);

    // Word load at 0x100: arready after 2 cycles, rvalid after 3.
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 1'b1, 5'd7, 1'b0, 32'hDEADBEEF, 0, 0, 2, 3, 0,
           o_wb, o_addr, o_strb, o_wdata, o_hsk);
    check("lit_word_load_data", o_wb, 32'hDEADBEEF);
    check("lit_word_load_cycle", o_hsk, 3);
    check("lit_word_load_addr", o_addr, 32'h100);

    // Byte store 0xAB at 0x103.
    run_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h103, 32'h000000AB, 1'b0, 5'd1, 1'b0, 32'd0, 0, 0, 0, 0, 0,
           o_wb, o_addr, o_strb, o_wdata, o_hsk);
    check("lit_byte_store_addr", o_addr, 32'h100);
    check("lit_byte_store_strb", o_strb, 4'b1000);
    check("lit_byte_store_data", o_wdata, 32'hAB000000);

    // Half load at 0x102, signed then unsigned.
    run_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'd0, 1'b1, 5'd2, 1'b0, 32'h80010000, 0, 0, 1, 1, 0,
           o_wb, o_addr, o_strb, o_wdata, o_hsk);
    check("lit_half_signed", o_wb, 32'hFFFF8001);
    run_op(1'b1, 1'b0, 2'd1, 1'b1, 32'h102, 32'd0, 1'b1, 5'd2, 1'b0, 32'h80010000, 0, 0, 0, 2, 0,
           o_wb, o_addr, o_strb, o_wdata, o_hsk);
    check("lit_half_unsigned", o_wb, 32'h00008001);

    // Store with wready 3 cycles ahead of awready.
    run_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678, 1'b0, 5'd3, 1'b0, 32'd0, 3, 0, 0, 0, 0,
           o_wb, o_addr, o_strb, o_wdata, o_hsk);
    check("lit_split_store_resp_cycle", o_hsk, 4);
    check("lit_split_store_strb", o_strb, 4'b1111);

    // ALU pass-through and a flushed load.
    run_op(1'b0, 1'b0, 2'd0, 1'b0, 32'h12345678, 32'd0, 1'b1, 5'd9, 1'b0, 32'd0, 0, 0, 0, 0, 0,
           o_wb, o_addr, o_strb, o_wdata, o_hsk);
    check("lit_alu_passthrough", o_wb, 32'h12345678);
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'd0, 1'b1, 5'd4, 1'b1, 32'd0, 0, 0, 0, 0, 0,
           o_wb, o_addr, o_strb, o_wdata, o_hsk);
    check("lit_flush_wb_we", wb_we, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'd0, 1'b1, 5'd5, 1'b0, 32'd0, 0, 0, 0, 0, 0,
           o_wb, o_addr, o_strb, o_wdata, o_hsk);
    check("lit_misalign_exc", exc_misalign, 1'b1);
    check("lit_misalign_arvalid", m_arvalid, 1'b0);
    check("lit_misalign_wb_we", wb_we, 1'b0);
`endif

    // Reset in the middle of a read that never gets arready.
    @(posedge clk); #1;
    pipe_ready = 1'b1; in_read = 1'b1; in_write = 1'b0; in_size = 2'd2; in_addr = 32'h300;
    in_rd_we = 1'b1; in_rd = 5'd6; pipe_flush = 1'b0;
    @(posedge clk); #1;
    pipe_ready = 1'b0;
    e_pv = 1'b0; e_aw = 1'b0; e_w = 1'b0; e_b = 1'b0; e_ar = 1'b1; e_r = 1'b1;
    e_exc = 1'b0; e_we = 1'b1; e_rd = 5'd6; e_wb_chk = 1'b0; e_st_chk = 1'b0; e_ld_chk = 1'b1; e_addr = 32'h300;
    @(negedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    set_idle_exp();
    e_we = 1'b0; e_rd = 5'd0; e_wb_chk = 1'b1; e_wb = 32'd0; e_ld_chk = 1'b0;
    @(negedge clk);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 150; n++) begin
      int kind;
      logic [31:0] a;
      logic [1:0] sz;
      kind = $urandom_range(0, 3);
      sz   = 2'($urandom_range(0, 2));
      a    = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~32'd3;
      run_op(kind == 1 || kind == 3, kind == 2, sz, 1'($urandom_range(0, 1)), a, $urandom,
             1'($urandom_range(0, 1)), 5'($urandom), kind == 3, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 4), $urandom_range(0, 3),
             o_wb, o_addr, o_strb, o_wdata, o_hsk);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
